// File: rtl/alu_pkg.sv
// alu_pkg: opcode encodings, condition-code bit positions and shifter modes for alu_core
package alu_pkg;

    localparam logic [3:0] OP_ADD  = 4'b0001;
    localparam logic [3:0] OP_SUB  = 4'b0010;
    localparam logic [3:0] OP_SHL  = 4'b0101;
    localparam logic [3:0] OP_SHAR = 4'b0110;
    localparam logic [3:0] OP_SHLR = 4'b0111;
    localparam logic [3:0] OP_RL   = 4'b1000;
    localparam logic [3:0] OP_RR   = 4'b1001;
    localparam logic [3:0] OP_AND  = 4'b1011;
    localparam logic [3:0] OP_OR   = 4'b1100;
    localparam logic [3:0] OP_XOR  = 4'b1101;
    localparam logic [3:0] OP_NOT  = 4'b1110;
    localparam logic [3:0] OP_MUL  = 4'b1111;

    localparam int CC_N = 3;
    localparam int CC_Z = 2;
    localparam int CC_C = 1;
    localparam int CC_V = 0;

    typedef enum logic [2:0] {SH_SHL, SH_SHAR, SH_SHLR, SH_RL, SH_RR} shmode_t;

endpackage

// File: rtl/alu_shifter.sv
// alu_shifter: combinational barrel shifter/rotator with last-bit-out carry
module alu_shifter
    import alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0]         a,
    input  logic [$clog2(WIDTH)-1:0] n,
    input  shmode_t                  mode,
    output logic [WIDTH-1:0]         y,
    output logic                     co
);

    logic [WIDTH:0]   left;
    logic [WIDTH:0]   right;
    logic [WIDTH:0]   arith;
    logic [WIDTH-1:0] rotl;
    logic [WIDTH-1:0] rotr;

    // one guard bit beside the operand catches the last bit shifted out; n=0 leaves it 0
    assign left  = {1'b0, a} << n;
    assign right = {a, 1'b0} >> n;
    assign arith = $signed({a, 1'b0}) >>> n;
    assign rotl  = (a << n) | (a >> (WIDTH - n));
    assign rotr  = (a >> n) | (a << (WIDTH - n));

    // select the shifted value and carry for the requested mode; rotates never set carry
    always_comb begin
        y  = left[WIDTH-1:0];
        co = left[WIDTH];
        case (mode)
            SH_SHAR: begin y = arith[WIDTH:1]; co = arith[0]; end
            SH_SHLR: begin y = right[WIDTH:1]; co = right[0]; end
            SH_RL:   begin y = rotl; co = 1'b0; end
            SH_RR:   begin y = rotr; co = 1'b0; end
            default: ;
        endcase
    end

endmodule

// File: rtl/alu_core.sv
// alu_core: registered ALU with NZCV flags; define ALU_MUL_EN to build the multiplier
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] valA,
    input  logic [WIDTH-1:0] valB,
    input  logic [3:0]       aluop,
    input  logic             sub,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       cc
);

    logic             do_sub;
    logic [WIDTH-1:0] bx;
    logic [WIDTH:0]   sum;
    logic             add_v;
    shmode_t          mode;
    logic [WIDTH-1:0] sh_y;
    logic             sh_c;
    logic [WIDTH-1:0] res;
    logic [3:0]       flags;

    // SUB always subtracts; sub only matters for ADD, other ops ignore the adder
    assign do_sub = aluop == OP_SUB || sub;
    assign bx     = do_sub ? ~valB : valB;
    assign sum    = {1'b0, valA} + {1'b0, bx} + (WIDTH+1)'(do_sub);
    assign add_v  = (valA[WIDTH-1] == bx[WIDTH-1]) && (sum[WIDTH-1] != valA[WIDTH-1]);

    assign mode = aluop == OP_SHAR ? SH_SHAR :
                  aluop == OP_SHLR ? SH_SHLR :
                  aluop == OP_RL   ? SH_RL   :
                  aluop == OP_RR   ? SH_RR   : SH_SHL;

    alu_shifter #(.WIDTH(WIDTH)) u_shifter (
        .a    (valA),
        .n    (valB[$clog2(WIDTH)-1:0]),
        .mode (mode),
        .y    (sh_y),
        .co   (sh_c)
    );

`ifdef ALU_MUL_EN
    logic [2*WIDTH-1:0] prod;
    assign prod = {{WIDTH{1'b0}}, valA} * {{WIDTH{1'b0}}, valB};
`endif

    // pick the op result and its C/V; N and Z always follow the selected result
    always_comb begin
        res   = '0;
        flags = '0;
        case (aluop)
            OP_ADD, OP_SUB: begin
                res         = sum[WIDTH-1:0];
                flags[CC_C] = sum[WIDTH];
                flags[CC_V] = add_v;
            end
            OP_SHL, OP_SHAR, OP_SHLR, OP_RL, OP_RR: begin
                res         = sh_y;
                flags[CC_C] = sh_c;
            end
            OP_AND: res = valA & valB;
            OP_OR:  res = valA | valB;
            OP_XOR: res = valA ^ valB;
            OP_NOT: res = ~valB;
`ifdef ALU_MUL_EN
            OP_MUL: begin
                res         = prod[WIDTH-1:0];
                flags[CC_C] = |prod[2*WIDTH-1:WIDTH];
                flags[CC_V] = |prod[2*WIDTH-1:WIDTH];
            end
`endif
            default: ;
        endcase
        flags[CC_N] = res[WIDTH-1];
        flags[CC_Z] = res == '0;
    end

    // output register; reset overrides whatever op is presented
    always_ff @(posedge clk) begin
        if (reset) begin
            result <= '0;
            cc     <= '0;
        end else begin
            result <= res;
            cc     <= flags;
        end
    end

endmodule

// File: tb/tb_alu_core.sv
// tb_alu_core: directed and randomized checks of alu_core against a behavioural model
module tb_alu_core;
    import alu_pkg::*;

    typedef struct packed {
        logic [15:0] a;
        logic [15:0] b;
        logic [3:0]  op;
        logic        s;
        logic        xa;
        logic [15:0] r;
        logic [3:0]  cc;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] valA = '0;
    logic [15:0] valB = '0;
    logic [3:0]  aluop = '0;
    logic        sub = 1'b0;
    logic [15:0] result;
    logic [3:0]  cc;
    int          checks = 0;
    int          errors = 0;

    alu_core #(.WIDTH(16)) dut (
        .clk    (clk),
        .reset  (reset),
        .valA   (valA),
        .valB   (valB),
        .aluop  (aluop),
        .sub    (sub),
        .result (result),
        .cc     (cc)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    // reference: {N,Z,C,V,result} from plain integer arithmetic and bit-at-a-time shifting
    function automatic logic [19:0] model(input logic [15:0] a, input logic [15:0] b,
                                          input logic [3:0] op, input logic s);
        logic [15:0] r;
        logic        c;
        logic        v;
        int          n;
        int          t;
        int          sa;
        int          sb;
        longint      p;
        r = 16'd0;
        c = 1'b0;
        v = 1'b0;
        n = int'(b) % 16;
        sa = $signed(a);
        sb = $signed(b);
        case (op)
            4'b0001, 4'b0010: begin
                if (op == 4'b0010 || s) begin
                    t = int'(a) - int'(b);
                    c = a >= b;
                    v = (sa - sb > 32767) || (sa - sb < -32768);
                end else begin
                    t = int'(a) + int'(b);
                    c = t > 65535;
                    v = (sa + sb > 32767) || (sa + sb < -32768);
                end
                r = t[15:0];
            end
            4'b0101: begin r = a; for (int i = 0; i < n; i++) begin c = r[15]; r = {r[14:0], 1'b0}; end end
            4'b0110: begin r = a; for (int i = 0; i < n; i++) begin c = r[0]; r = {r[15], r[15:1]}; end end
            4'b0111: begin r = a; for (int i = 0; i < n; i++) begin c = r[0]; r = {1'b0, r[15:1]}; end end
            4'b1000: begin r = a; for (int i = 0; i < n; i++) r = {r[14:0], r[15]}; end
            4'b1001: begin r = a; for (int i = 0; i < n; i++) r = {r[0], r[15:1]}; end
            4'b1011: r = a & b;
            4'b1100: r = a | b;
            4'b1101: r = a ^ b;
            4'b1110: r = ~b;
`ifdef ALU_MUL_EN
            4'b1111: begin
                p = longint'(a) * longint'(b);
                r = p[15:0];
                c = (p >> 16) != 0;
                v = c;
            end
`endif
            default: r = 16'd0;
        endcase
        return {r[15], r == 16'd0, c, v, r};
    endfunction

    task automatic apply(input logic [15:0] a, input logic [15:0] b, input logic [3:0] op,
                         input logic s, input logic xa);
        valA  = xa ? 16'bx : a;
        valB  = b;
        aluop = op;
        sub   = s;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            apply(16'h7FFF, 16'h0001, OP_ADD, 1'b0, 1'b0);
            checks++;
            if ({cc, result} !== 20'h0) begin
                errors++;
                $display("FAIL reset[%0d]: got result=%h cc=%b, expected result=0000 cc=0000", i, result, cc);
            end
        end
        reset = 1'b0;
    endtask

    task automatic run_table(input string name, input vec_t q[$]);
        foreach (q[i]) begin
            apply(q[i].a, q[i].b, q[i].op, q[i].s, q[i].xa);
            checks++;
            if (result !== q[i].r || cc !== q[i].cc) begin
                errors++;
                $display("FAIL %s[%0d]: got result=%h cc=%b, expected result=%h cc=%b",
                         name, i, result, cc, q[i].r, q[i].cc);
            end
        end
    endtask

    task automatic test_addsub();
        vec_t q[$];
        q.push_back('{16'd10000, 16'd15000, OP_ADD, 1'b0, 1'b0, 16'd25000, 4'b0000});
        q.push_back('{16'd32767, 16'd1,     OP_ADD, 1'b0, 1'b0, 16'd32768, 4'b1001});
        q.push_back('{16'd15000, 16'd5000,  OP_ADD, 1'b1, 1'b0, 16'd10000, 4'b0010});
        q.push_back('{16'd20000, 16'd40000, OP_SUB, 1'b0, 1'b0, 16'd45536, 4'b1001});
        q.push_back('{16'd60000, 16'd60000, OP_SUB, 1'b0, 1'b0, 16'd0,     4'b0110});
        run_table("addsub", q);
    endtask

    task automatic test_mul();
        vec_t q[$];
`ifdef ALU_MUL_EN
        q.push_back('{16'd100,   16'd200,   OP_MUL, 1'b0, 1'b0, 16'd20000, 4'b0000});
        q.push_back('{16'd60000, 16'd60000, OP_MUL, 1'b0, 1'b0, 16'hA400,  4'b1011});
        q.push_back('{16'd54321, 16'd0,     OP_MUL, 1'b0, 1'b0, 16'd0,     4'b0100});
`else
        q.push_back('{16'd100,   16'd200,   OP_MUL, 1'b0, 1'b0, 16'd0,     4'b0100});
`endif
        run_table("mul", q);
    endtask

    task automatic test_shift_logic();
        vec_t q[$];
        q.push_back('{16'h00FF, 16'd4,    OP_SHL,  1'b0, 1'b0, 16'h0FF0, 4'b0000});
        q.push_back('{16'hFF00, 16'd4,    OP_SHAR, 1'b0, 1'b0, 16'hFFF0, 4'b1000});
        q.push_back('{16'h0FFF, 16'd4,    OP_SHAR, 1'b0, 1'b0, 16'h00FF, 4'b0010});
        q.push_back('{16'hFFFF, 16'd15,   OP_SHLR, 1'b0, 1'b0, 16'h0001, 4'b0010});
        q.push_back('{16'h8001, 16'h0010, OP_SHL,  1'b0, 1'b0, 16'h8001, 4'b1000});
        q.push_back('{16'hF0FF, 16'hFFF4, OP_SHLR, 1'b0, 1'b0, 16'h0F0F, 4'b0001 << 1});
        q.push_back('{16'hF0FF, 16'd4,    OP_RL,   1'b0, 1'b0, 16'h0FFF, 4'b0000});
        q.push_back('{16'hF0FF, 16'd4,    OP_RR,   1'b0, 1'b0, 16'hFF0F, 4'b1000});
        q.push_back('{16'hFF00, 16'h00FF, OP_AND,  1'b0, 1'b0, 16'h0000, 4'b0100});
        q.push_back('{16'hFF00, 16'h00FF, OP_OR,   1'b0, 1'b0, 16'hFFFF, 4'b1000});
        q.push_back('{16'hAAAA, 16'hAA55, OP_XOR,  1'b0, 1'b0, 16'h00FF, 4'b0000});
        q.push_back('{16'h0000, 16'hFF00, OP_NOT,  1'b0, 1'b1, 16'h00FF, 4'b0000});
        run_table("shift_logic", q);
    endtask

    task automatic test_unused();
        logic [3:0] ops[4] = '{4'b0000, 4'b0011, 4'b0100, 4'b1010};
        foreach (ops[i]) begin
            apply(16'h1234, 16'h4321, ops[i], 1'b1, 1'b0);
            checks++;
            if (result !== 16'h0 || cc !== 4'b0100) begin
                errors++;
                $display("FAIL unused[%b]: got result=%h cc=%b, expected result=0000 cc=0100", ops[i], result, cc);
            end
        end
    endtask

    task automatic test_mid_reset();
        apply(16'd1, 16'd2, OP_ADD, 1'b0, 1'b0);
        checks++;
        if (result !== 16'd3 || cc !== 4'b0000) begin
            errors++;
            $display("FAIL mid_reset_pre: got result=%h cc=%b, expected result=0003 cc=0000", result, cc);
        end
        reset = 1'b1;
        apply(16'hFFFF, 16'hFFFF, OP_ADD, 1'b0, 1'b0);
        checks++;
        if (result !== 16'd0 || cc !== 4'b0000) begin
            errors++;
            $display("FAIL mid_reset: got result=%h cc=%b, expected result=0000 cc=0000", result, cc);
        end
        reset = 1'b0;
        apply(16'd10000, 16'd15000, OP_ADD, 1'b0, 1'b0);
        checks++;
        if (result !== 16'd25000 || cc !== 4'b0000) begin
            errors++;
            $display("FAIL mid_reset_post: got result=%h cc=%b, expected result=61a8 cc=0000", result, cc);
        end
    endtask

    function automatic logic [15:0] pick();
        case ($urandom_range(0, 5))
            0: return 16'h0000;
            1: return 16'hFFFF;
            2: return 16'h8000;
            3: return 16'h7FFF;
            default: return 16'($urandom);
        endcase
    endfunction

    task automatic test_random(input string name, input int count, input logic alu_only);
        logic [15:0] a;
        logic [15:0] b;
        logic [3:0]  op;
        logic        s;
        logic [19:0] exp;
        for (int i = 0; i < count; i++) begin
            a  = pick();
            b  = pick();
            op = alu_only ? ($urandom_range(0, 1) ? OP_ADD : OP_SUB) : 4'($urandom_range(0, 15));
            s  = 1'($urandom);
            exp = model(a, b, op, s);
            apply(a, b, op, s, 1'b0);
            checks++;
            if ({cc, result} !== exp) begin
                errors++;
                $display("FAIL %s[%0d] op=%b a=%h b=%h sub=%b: got result=%h cc=%b, expected result=%h cc=%b",
                         name, i, op, a, b, s, result, cc, exp[15:0], exp[19:16]);
            end
        end
    endtask

    task automatic test_back_to_back();
        test_random("back_to_back", 60, 1'b1);
    endtask

    initial begin
        test_reset();
        test_addsub();
        test_mul();
        test_shift_logic();
        test_unused();
        test_mid_reset();
        test_back_to_back();
        test_random("random", 600, 1'b0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
